// File: rtl/cs_decode_pkg.sv
// Shared types, state encodings, default memory map and priority encoder
// for the cs_decode_ws address decoder.
package cs_decode_pkg;

    localparam int MAX_CS = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_MISS   = 2'd3;

    // Default map: region 0 in the LSBs
    localparam logic [63:0] DEF_REGION_BASE = {16'h5000, 16'h6000, 16'h0000, 16'h8000};
    localparam logic [63:0] DEF_REGION_MASK = {16'hF000, 16'hE000, 16'hC000, 16'h8000};
    localparam logic [11:0] DEF_REGION_WS   = {3'd3, 3'd2, 3'd0, 3'd1};

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } enc_t;

    // Lowest set bit wins, so overlapping regions resolve to the smaller index.
    function automatic enc_t prio_enc(input logic [MAX_CS-1:0] hits);
        enc_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = MAX_CS - 1; i >= 0; i--) begin
            if (hits[i]) begin
                r.found = 1'b1;
                r.idx   = 5'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cs_decode_ws_phi2_sync.sv
// Two-flop synchroniser for the CPU PHI2 clock plus an edge-detect flop
// that produces single-clk rise/fall pulses.
module phi2_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], async_in};
        end
    end

    assign level = sync_reg[1];
    assign rise  = sync_reg[1] & ~sync_reg[2];
    assign fall  = ~sync_reg[1] & sync_reg[2];

endmodule

// File: rtl/cs_decode_ws.sv
// 6502 address decoder with registered chip selects and OE/WE strobes.
// Define WAIT_STATE_EN to build the per-region wait-state counter and RDY stretch.
module cs_decode_ws
    import cs_decode_pkg::*;
#(
    parameter int                       ADDR_W      = 16,
    parameter int                       NUM_CS      = 4,
    parameter int                       WS_W        = 3,
    parameter logic [NUM_CS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_CS*ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK,
    parameter logic [NUM_CS*WS_W-1:0]   REGION_WS   = DEF_REGION_WS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       phi2,
    input  logic [ADDR_W-1:0]          addr,
    input  logic                       rw,
    output logic [NUM_CS-1:0]          cs_n,
    output logic                       oe_n,
    output logic                       we_n,
    output logic                       rdy,
    output logic [$clog2(NUM_CS)-1:0]  hit_idx,
    output logic                       miss
);

    localparam int IDX_W = $clog2(NUM_CS);

    logic phi2_level;
    logic phi2_rise;
    logic phi2_fall;

    phi2_sync u_phi2_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (phi2),
        .level    (phi2_level),
        .rise     (phi2_rise),
        .fall     (phi2_fall)
    );

    logic [MAX_CS-1:0] hits;
    enc_t              enc;
    logic [IDX_W-1:0]  enc_idx;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_CS; gi++) begin : g_match
            if (gi < NUM_CS) begin : g_used
                assign hits[gi] = ((addr & REGION_MASK[gi*ADDR_W +: ADDR_W])
                                   == REGION_BASE[gi*ADDR_W +: ADDR_W]);
            end else begin : g_unused
                assign hits[gi] = 1'b0;
            end
        end
    endgenerate

    assign enc     = prio_enc(hits);
    assign enc_idx = IDX_W'(enc.idx);

`ifdef WAIT_STATE_EN
    logic [WS_W-1:0] ws_tab [NUM_CS];
    logic [WS_W-1:0] cnt_reg;

    generate
        for (gi = 0; gi < NUM_CS; gi++) begin : g_ws
            assign ws_tab[gi] = REGION_WS[gi*WS_W +: WS_W];
        end
    endgenerate
`endif

    logic [1:0]        state_reg, state_next;
    logic [IDX_W-1:0]  hit_reg, hit_next;
    logic              rw_reg, rw_next;
    logic [NUM_CS-1:0] cs_n_reg, cs_n_next;
    logic              oe_n_reg, oe_n_next;
    logic              we_n_reg, we_n_next;
    logic              miss_reg, miss_next;
    logic              sel_next;

    always_comb begin
        state_next = state_reg;
        hit_next   = hit_reg;
        rw_next    = rw_reg;
        case (state_reg)
            ST_IDLE: begin
                if (phi2_rise) begin
                    rw_next = rw;
                    if (!enc.found) begin
                        state_next = ST_MISS;
                    end else begin
                        hit_next = enc_idx;
`ifdef WAIT_STATE_EN
                        state_next = (ws_tab[enc_idx] == '0) ? ST_ACTIVE : ST_WAIT;
`else
                        state_next = ST_ACTIVE;
`endif
                    end
                end
            end
            ST_WAIT: begin
`ifdef WAIT_STATE_EN
                if (cnt_reg <= WS_W'(1)) begin
                    state_next = ST_ACTIVE;
                end
`else
                state_next = ST_IDLE;
`endif
            end
            // A rise here means the fall was missed; drop back and decode afresh.
            ST_ACTIVE: begin
                if (phi2_fall || phi2_rise) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they switch together.
    always_comb begin
        sel_next  = (state_next == ST_ACTIVE) || (state_next == ST_WAIT);
        cs_n_next = sel_next ? ~(NUM_CS'(1) << hit_next) : '1;
        oe_n_next = !(sel_next && rw_next);
        we_n_next = !((state_next == ST_ACTIVE) && !rw_next && phi2_level);
        miss_next = (state_next == ST_MISS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            hit_reg   <= '0;
            rw_reg    <= 1'b1;
            cs_n_reg  <= '1;
            oe_n_reg  <= 1'b1;
            we_n_reg  <= 1'b1;
            miss_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            hit_reg   <= hit_next;
            rw_reg    <= rw_next;
            cs_n_reg  <= cs_n_next;
            oe_n_reg  <= oe_n_next;
            we_n_reg  <= we_n_next;
            miss_reg  <= miss_next;
        end
    end

`ifdef WAIT_STATE_EN
    logic rdy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            rdy_reg <= 1'b1;
        end else begin
            rdy_reg <= (state_next != ST_WAIT);
            if (state_reg == ST_IDLE && state_next == ST_WAIT) begin
                cnt_reg <= ws_tab[enc_idx];
            end else if (state_reg == ST_WAIT) begin
                cnt_reg <= cnt_reg - WS_W'(1);
            end
        end
    end

    assign rdy = rdy_reg;
`else
    assign rdy = 1'b1;
`endif

    assign cs_n    = cs_n_reg;
    assign oe_n    = oe_n_reg;
    assign we_n    = we_n_reg;
    assign hit_idx = hit_reg;
    assign miss    = miss_reg;

endmodule

// File: tb/tb_cs_decode_ws.sv
// Scoreboard bench for cs_decode_ws: stimulus pushes expected decodes,
// a monitor pops them whenever a chip select or miss appears.
module tb_cs_decode_ws;

`ifdef WAIT_STATE_EN
    localparam bit WS_ON = 1'b1;
`else
    localparam bit WS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        phi2;
    logic [15:0] addr;
    logic        rw;
    logic [3:0]  cs_n, ov_cs_n;
    logic        oe_n, we_n, rdy, miss;
    logic        ov_oe_n, ov_we_n, ov_rdy, ov_miss;
    logic [1:0]  hit_idx, ov_hit_idx;

    always #5 clk = ~clk;

    cs_decode_ws dut (
        .clk     (clk),
        .rst     (rst),
        .phi2    (phi2),
        .addr    (addr),
        .rw      (rw),
        .cs_n    (cs_n),
        .oe_n    (oe_n),
        .we_n    (we_n),
        .rdy     (rdy),
        .hit_idx (hit_idx),
        .miss    (miss)
    );

    // Region 3 moved on top of region 0 so 0x8000 hits both.
    cs_decode_ws #(
        .REGION_BASE ({16'h8000, 16'h6000, 16'h0000, 16'h8000}),
        .REGION_MASK ({16'h8000, 16'hE000, 16'hC000, 16'h8000})
    ) dut_ov (
        .clk     (clk),
        .rst     (rst),
        .phi2    (phi2),
        .addr    (addr),
        .rw      (rw),
        .cs_n    (ov_cs_n),
        .oe_n    (ov_oe_n),
        .we_n    (ov_we_n),
        .rdy     (ov_rdy),
        .hit_idx (ov_hit_idx),
        .miss    (ov_miss)
    );

    typedef struct {
        logic [15:0] a;
        logic [3:0]  cs;
        logic [1:0]  hit;
        bit          is_miss;
        bit          rd;
        int          ws;
        bit          chk_ov;
        bit          abort;
        int          rise_cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   fall_cyc = 0;
    bit   busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic chk_rng(input string nm, input int v, input int lo, input int hi);
        n_cmp++;
        if (v < lo || v > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", nm, v, lo, hi, $time);
        end
    endtask

    function automatic int wsf(input int k);
        return WS_ON ? k : 0;
    endfunction

    task automatic bus_cycle(input logic [15:0] a, input bit rd, input logic [3:0] ecs,
                             input logic [1:0] eh, input bit em, input int ews,
                             input bit ov, input bit ab);
        exp_t e;
        addr = a;
        rw   = rd;
        @(posedge clk);
        #2 phi2 = 1'b1;
        e.a = a; e.cs = ecs; e.hit = eh; e.is_miss = em; e.rd = rd;
        e.ws = ews; e.chk_ov = ov; e.abort = ab; e.rise_cyc = cyc;
        q.push_back(e);
        $display("issue addr=%04h rw=%0d expect cs_n=%04b hit=%0d miss=%0d ws=%0d",
                 a, rd, ecs, eh, em, ews);
        if (!ab) begin
            // Bus changes after the latch must not affect the decode.
            repeat (6) @(posedge clk);
            #2 addr = 16'h4000;
            rw = ~rd;
            repeat (6) @(posedge clk);
            #2 phi2 = 1'b0;
            fall_cyc = cyc;
            repeat (12) @(posedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && we_n === 1'b0) chk("we_n_vs_rdy", {31'd0, rdy}, 32'd1);
    end

    // Monitor
    initial begin
        exp_t e;
        int   n;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) continue;
            if (cs_n !== 4'hF || miss !== 1'b0) begin
                busy = 1'b1;
                if (q.size() == 0) begin
                    chk("unexpected_select", {27'd0, cs_n, miss}, {27'd0, 4'hF, 1'b0});
                    n = 0;
                    while ((cs_n !== 4'hF || miss !== 1'b0) && n < 40) begin
                        n++;
                        @(negedge clk);
                    end
                end else begin
                    e = q.pop_front();
                    chk("cs_n", {28'd0, cs_n}, {28'd0, e.cs});
                    chk("miss", {31'd0, miss}, {31'd0, e.is_miss});
                    if (!e.abort) chk_rng("assert_latency", cyc - e.rise_cyc, 3, 4);
                    if (e.is_miss) begin
                        @(negedge clk);
                        chk("miss_pulse_width", {31'd0, miss}, 32'd0);
                        chk("cs_n_after_miss", {28'd0, cs_n}, 32'hF);
                    end else begin
                        chk("hit_idx", {30'd0, hit_idx}, {30'd0, e.hit});
                        chk("oe_n", {31'd0, oe_n}, {31'd0, !e.rd});
                        if (e.chk_ov) begin
                            chk("ov_cs_n", {28'd0, ov_cs_n}, {28'd0, e.cs});
                            chk("ov_hit_idx", {30'd0, ov_hit_idx}, {30'd0, e.hit});
                        end
                        if (!e.abort) begin
                            n = 0;
                            while (rdy === 1'b0 && n < 16) begin
                                chk("we_n_in_wait", {31'd0, we_n}, 32'd1);
                                n++;
                                @(negedge clk);
                            end
                            chk("rdy_low_cycles", n, e.ws);
                            chk("cs_n_held", {28'd0, cs_n}, {28'd0, e.cs});
                            chk("we_n_active", {31'd0, we_n}, {31'd0, e.rd});
                        end
                        n = 0;
                        while (cs_n !== 4'hF && n < 40) begin
                            n++;
                            @(negedge clk);
                        end
                        chk("cs_n_release", {28'd0, cs_n}, 32'hF);
                        chk("oe_n_release", {31'd0, oe_n}, 32'd1);
                        chk("we_n_release", {31'd0, we_n}, 32'd1);
                        chk("rdy_release", {31'd0, rdy}, 32'd1);
                        if (!e.abort) chk_rng("release_latency", cyc - fall_cyc, 3, 4);
                    end
                    $display("done  addr=%04h cs_n=%04b hit=%0d miss=%0d", e.a, e.cs, e.hit, e.is_miss);
                end
                busy = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst  = 1'b1;
        phi2 = 1'b0;
        addr = 16'h0000;
        rw   = 1'b1;

        // Reset held with phi2 toggling.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2 phi2 = ~phi2;
            @(negedge clk);
            chk("rst_cs_n", {28'd0, cs_n}, 32'hF);
            chk("rst_rdy", {31'd0, rdy}, 32'd1);
            chk("rst_oe_n", {31'd0, oe_n}, 32'd1);
            chk("rst_we_n", {31'd0, we_n}, 32'd1);
            chk("rst_hit_idx", {30'd0, hit_idx}, 32'd0);
            chk("rst_miss", {31'd0, miss}, 32'd0);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);

        //         addr      rd  cs_n     hit miss ws       ov  abort
        bus_cycle(16'h1234, 1, 4'b1101, 1, 0, wsf(0), 0, 0);
        bus_cycle(16'h6000, 0, 4'b1011, 2, 0, wsf(2), 0, 0);
        bus_cycle(16'h8000, 1, 4'b1110, 0, 0, wsf(1), 1, 0);
        bus_cycle(16'h4000, 1, 4'b1111, 0, 1, 0,      0, 0);
        bus_cycle(16'h3FFF, 0, 4'b1101, 1, 0, wsf(0), 0, 0);
        bus_cycle(16'h7FFF, 1, 4'b1011, 2, 0, wsf(2), 0, 0);
        bus_cycle(16'h5FFF, 1, 4'b0111, 3, 0, wsf(3), 0, 0);
        bus_cycle(16'hFFFF, 0, 4'b1110, 0, 0, wsf(1), 0, 0);
        bus_cycle(16'h4FFF, 0, 4'b1111, 0, 1, 0,      0, 0);

        // Reset one clk into the wait-state stretch at 0x5000.
        bus_cycle(16'h5000, 1, 4'b0111, 3, 0, wsf(3), 0, 1);
        n = 0;
        @(negedge clk);
        while (cs_n === 4'hF && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("rst_wait_select_seen", {28'd0, cs_n}, 32'h7);
        @(posedge clk);
        #2 rst = 1'b1;
        phi2 = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_wait_cs_n", {28'd0, cs_n}, 32'hF);
        chk("rst_wait_rdy", {31'd0, rdy}, 32'd1);
        chk("rst_wait_oe_n", {31'd0, oe_n}, 32'd1);
        chk("rst_wait_hit_idx", {30'd0, hit_idx}, 32'd0);
        repeat (12) @(posedge clk);

        bus_cycle(16'h5000, 1, 4'b0111, 3, 0, wsf(3), 0, 0);

        n = 0;
        while ((q.size() != 0 || busy) && n < 100) begin
            n++;
            @(posedge clk);
        end
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
